// File: rtl/sudoku_check_sequencer_if.sv
// -----------------------------------------------------------------------------
// sudoku_check_sequencer_if
//
// Bundles the signals between the board check sequencer, the main FSM that
// requests a check, and the board RAM read port.
//
// Handshake semantics:
//   start  : request from the main FSM. It is sampled only while the sequencer
//            is idle (busy=0, done=0). Assertions at any other time are ignored.
//   busy   : high from the cycle after start is accepted until the cycle
//            before done.
//   done   : single-cycle pulse. solved/conflict/err_group/empty_cnt are final
//            from this cycle and hold until the next accepted start.
//   rd_en  : read strobe with rd_addr. rd_data carries the cell value for the
//            read issued in the previous cycle (one-cycle RAM latency).
//
// Signals:
//   start      main FSM  -> sequencer   check request
//   rd_en      sequencer -> RAM         read strobe
//   rd_addr    sequencer -> RAM         cell address row*9+col, 0..80
//   rd_data    RAM       -> sequencer   cell value (0 empty, 1..9, 10..15 illegal)
//   busy       sequencer -> main FSM    scan in progress
//   done       sequencer -> main FSM    results final (one cycle)
//   solved     sequencer -> main FSM    no conflict and no empty cell
//   conflict   sequencer -> main FSM    at least one group invalid
//   err_group  sequencer -> main FSM    first invalid group 0..26
//   empty_cnt  sequencer -> main FSM    number of empty cells 0..81
//
// Modports: master = the sequencer, slave = its environment.
// -----------------------------------------------------------------------------
interface sudoku_check_sequencer_if;
    logic       start;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic [3:0] rd_data;
    logic       busy;
    logic       done;
    logic       solved;
    logic       conflict;
    logic [4:0] err_group;
    logic [6:0] empty_cnt;

    modport master (
        input  start,
        input  rd_data,
        output rd_en,
        output rd_addr,
        output busy,
        output done,
        output solved,
        output conflict,
        output err_group,
        output empty_cnt
    );

    modport slave (
        output start,
        output rd_data,
        input  rd_en,
        input  rd_addr,
        input  busy,
        input  done,
        input  solved,
        input  conflict,
        input  err_group,
        input  empty_cnt
    );
endinterface

// File: rtl/sudoku_check_sequencer.sv
// -----------------------------------------------------------------------------
// sudoku_check_sequencer
//
// Scans a 9x9 board held in RAM once per group (9 rows, 9 columns, 9 boxes:
// 243 reads, one per cycle), flags duplicate or out-of-range values, counts
// empty cells and reports solved / conflict / first offending group.
//
// Ports:
//   clka       system clock, rising edge
//   restart    asynchronous active-high reset
//   bus        sudoku_check_sequencer_if.master (start, RAM read port, results)
//   fsm_state  current FSM state (0 IDLE, 1 READ, 2 DRAIN, 3 DONE), debug
//
// The scan never stops early, so a check always takes the same number of
// cycles: start edge E0, read n during the cycle after E0+n, done during the
// cycle after E0+244.
// -----------------------------------------------------------------------------
module sudoku_check_sequencer #(
    parameter int CELLS = 81
) (
    input  logic                      clka,
    input  logic                      restart,
    sudoku_check_sequencer_if.master  bus,
    output logic [1:0]                fsm_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [4:0] LAST_GROUP = 5'd26;
    localparam logic [3:0] LAST_IDX   = 4'd8;
    localparam logic [6:0] MAX_EMPTY  = 7'(CELLS);

    logic [1:0] state;

    // Address-stage counters: group 0..26 and index within the group 0..8.
    logic [4:0] grp;
    logic [3:0] idx;

    // Evaluation-stage tags, one cycle behind the address stage so they line
    // up with rd_data.
    logic       ev_valid;
    logic [4:0] ev_grp;
    logic [3:0] ev_idx;

    logic [8:0] seen;
    logic       conflict_q;
    logic       solved_q;
    logic [4:0] err_q;
    logic [6:0] empty_q;

    // ------------------------------------------------------------------
    // Small constant divide/multiply helpers for the box mapping. Inputs
    // are at most 8, so a compare ladder replaces a real divider.
    // ------------------------------------------------------------------
    function automatic logic [1:0] div3(input logic [3:0] x);
        if (x >= 4'd6)      return 2'd2;
        else if (x >= 4'd3) return 2'd1;
        else                return 2'd0;
    endfunction

    function automatic logic [3:0] times3(input logic [1:0] x);
        return {1'b0, x, 1'b0} + {2'b00, x};
    endfunction

    function automatic logic [1:0] mod3(input logic [3:0] x);
        logic [3:0] rem;
        rem = x - times3(div3(x));
        return rem[1:0];
    endfunction

    // ------------------------------------------------------------------
    // Address generation: group/index -> (row, col) -> row*9+col.
    // ------------------------------------------------------------------
    logic [3:0] row_sel;
    logic [3:0] col_sel;
    logic [3:0] box_id;

    always_comb begin
        row_sel = 4'd0;
        col_sel = 4'd0;
        box_id  = 4'd0;
        if (grp < 5'd9) begin
            row_sel = grp[3:0];
            col_sel = idx;
        end else if (grp < 5'd18) begin
            row_sel = idx;
            col_sel = 4'(grp - 5'd9);
        end else begin
            // Box b covers rows 3*(b/3).. and cols 3*(b%3)..; the index
            // walks the box in row-major order.
            box_id  = 4'(grp - 5'd18);
            row_sel = times3(div3(box_id)) + {2'b00, div3(idx)};
            col_sel = times3(mod3(box_id)) + {2'b00, mod3(idx)};
        end
    end

    // 9*row = 8*row + row, then add the column.
    assign bus.rd_addr = {row_sel, 3'b000} + {3'b000, row_sel} + {3'b000, col_sel};

    // ------------------------------------------------------------------
    // Evaluation of the datum returned for the previous cycle's read.
    // ------------------------------------------------------------------
    logic [8:0] digit_bit;
    logic [8:0] seen_base;
    logic [8:0] seen_next;
    logic       illegal;
    logic       dup;
    logic       bad;
    logic       is_empty;
    logic       conflict_next;
    logic [6:0] empty_next;

    always_comb begin
        digit_bit = 9'd0;
        if (bus.rd_data >= 4'd1 && bus.rd_data <= 4'd9) begin
            digit_bit = 9'd1 << (bus.rd_data - 4'd1);
        end
        // The first cell of a group starts from an empty mask, so the
        // previous group's bits never leak into this one.
        seen_base     = (ev_idx == 4'd0) ? 9'd0 : seen;
        illegal       = (bus.rd_data > 4'd9);
        dup           = |(seen_base & digit_bit);
        bad           = ev_valid && (illegal || dup);
        seen_next     = seen_base | digit_bit;
        // Every cell appears exactly once in the row pass, so empties are
        // counted there only.
        is_empty      = ev_valid && (bus.rd_data == 4'd0) && (ev_grp < 5'd9);
        conflict_next = conflict_q | bad;
        empty_next    = empty_q;
        if (is_empty && (empty_q != MAX_EMPTY)) begin
            empty_next = empty_q + 7'd1;
        end
    end

    // ------------------------------------------------------------------
    // FSM, counters, pipeline tags and result registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state      <= S_IDLE;
            grp        <= 5'd0;
            idx        <= 4'd0;
            ev_valid   <= 1'b0;
            ev_grp     <= 5'd0;
            ev_idx     <= 4'd0;
            seen       <= 9'd0;
            conflict_q <= 1'b0;
            solved_q   <= 1'b0;
            err_q      <= 5'd0;
            empty_q    <= 7'd0;
        end else begin
            ev_valid <= (state == S_READ);
            ev_grp   <= grp;
            ev_idx   <= idx;

            if (ev_valid) begin
                seen       <= seen_next;
                conflict_q <= conflict_next;
                empty_q    <= empty_next;
                // Only the first invalid group is reported.
                if (bad && !conflict_q) begin
                    err_q <= ev_grp;
                end
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_READ;
                        grp        <= 5'd0;
                        idx        <= 4'd0;
                        conflict_q <= 1'b0;
                        solved_q   <= 1'b0;
                        err_q      <= 5'd0;
                        empty_q    <= 7'd0;
                    end
                end
                S_READ: begin
                    if (idx == LAST_IDX) begin
                        idx <= 4'd0;
                        if (grp == LAST_GROUP) begin
                            grp   <= 5'd0;
                            state <= S_DRAIN;
                        end else begin
                            grp <= grp + 5'd1;
                        end
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_DRAIN: begin
                    // The last datum is evaluated on this same edge, so the
                    // verdict uses the post-update conflict and count.
                    state    <= S_DONE;
                    solved_q <= !conflict_next && (empty_next == 7'd0);
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_en     = (state == S_READ);
    assign bus.busy      = (state == S_READ) || (state == S_DRAIN);
    assign bus.done      = (state == S_DONE);
    assign bus.solved    = solved_q;
    assign bus.conflict  = conflict_q;
    assign bus.err_group = err_q;
    assign bus.empty_cnt = empty_q;
    assign fsm_state     = state;

endmodule

// File: tb/tb_sudoku_check_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sudoku_check_sequencer
//
// Drives the sequencer against a one-cycle-latency board RAM model and checks
// timing, the address trace and the results against a reference model built
// from the board rules (group contents, digit counts).
// -----------------------------------------------------------------------------
module tb_sudoku_check_sequencer;

    // ---------------- clock / reset ----------------
    logic clka = 1'b0;
    logic restart = 1'b0;
    always #5 clka = ~clka;

    sudoku_check_sequencer_if bus ();
    logic [1:0] fsm_state;

    sudoku_check_sequencer dut (
        .clka      (clka),
        .restart   (restart),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    logic [3:0] board [81];
    int n_checks = 0;
    int n_fails  = 0;
    logic [6:0] trace [$];

    // Board RAM: registered read, data valid the cycle after rd_en.
    always @(posedge clka) begin
        if (restart) bus.rd_data <= 4'd0;
        else if (bus.rd_en) bus.rd_data <= board[bus.rd_addr];
    end

    // Address trace monitor, sampled away from the active edge.
    always @(negedge clka) begin
        if (bus.rd_en) trace.push_back(bus.rd_addr);
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int cell_of(int g, int k);
        int r, c, b;
        if (g < 9) begin
            r = g; c = k;
        end else if (g < 18) begin
            r = k; c = g - 9;
        end else begin
            b = g - 18;
            r = (b / 3) * 3 + k / 3;
            c = (b % 3) * 3 + k % 3;
        end
        return r * 9 + c;
    endfunction

    task automatic model(output logic exp_conflict, output int exp_err,
                         output int exp_empty, output logic exp_solved);
        int cnt [10];
        bit bad;
        int v;
        exp_conflict = 1'b0;
        exp_err      = 0;
        exp_empty    = 0;
        for (int g = 0; g < 27; g++) begin
            for (int d = 0; d < 10; d++) cnt[d] = 0;
            bad = 1'b0;
            for (int k = 0; k < 9; k++) begin
                v = int'(board[cell_of(g, k)]);
                if (v == 0) begin
                    if (g < 9) exp_empty++;
                end else if (v > 9) begin
                    bad = 1'b1;
                end else begin
                    cnt[v]++;
                    if (cnt[v] > 1) bad = 1'b1;
                end
            end
            if (bad && !exp_conflict) begin
                exp_conflict = 1'b1;
                exp_err      = g;
            end
        end
        exp_solved = !exp_conflict && (exp_empty == 0);
    endtask

    // ---------------- board builders ----------------
    task automatic clear_board();
        for (int i = 0; i < 81; i++) board[i] = 4'd0;
    endtask

    task automatic valid_board();
        int perm [9];
        int j, t;
        for (int i = 0; i < 9; i++) perm[i] = i + 1;
        for (int i = 8; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                board[r * 9 + c] = 4'(perm[(3 * (r % 3) + r / 3 + c) % 9]);
    endtask

    // ---------------- driver: one full check ----------------
    task automatic run_scan(input string name, input bit glitch);
        int cycles, busy_cycles, addr_bad;
        bit got_done;
        logic e_conf, e_solved;
        int e_err, e_empty;
        @(negedge clka);
        bus.start = 1'b1;
        @(posedge clka);
        #1 bus.start = 1'b0;
        trace.delete();
        cycles = 0; busy_cycles = 0; got_done = 1'b0;
        while (cycles < 400 && !got_done) begin
            @(negedge clka);
            cycles++;
            if (bus.done) got_done = 1'b1;
            else begin
                if (bus.busy) busy_cycles++;
                if (glitch) bus.start = ($urandom_range(0, 5) == 0);
            end
        end
        bus.start = 1'b0;
        check({name, ".done_seen"}, 32'(got_done), 32'd1);
        check({name, ".done_latency"}, 32'(cycles), 32'd245);
        check({name, ".busy_cycles"}, 32'(busy_cycles), 32'd244);
        check({name, ".rd_en_cycles"}, 32'(trace.size()), 32'd243);
        addr_bad = 0;
        for (int n = 0; n < trace.size() && n < 243; n++)
            if (int'(trace[n]) != cell_of(n / 9, n % 9)) addr_bad++;
        check({name, ".addr_trace"}, 32'(addr_bad), 32'd0);
        model(e_conf, e_err, e_empty, e_solved);
        check({name, ".conflict"}, 32'(bus.conflict), 32'(e_conf));
        check({name, ".err_group"}, 32'(bus.err_group), 32'(e_err));
        check({name, ".empty_cnt"}, 32'(bus.empty_cnt), 32'(e_empty));
        check({name, ".solved"}, 32'(bus.solved), 32'(e_solved));
        // done is a single pulse and results hold in IDLE.
        repeat (3) @(negedge clka);
        check({name, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({name, ".idle_state"}, 32'(fsm_state), 32'd0);
        check({name, ".hold_empty"}, 32'(bus.empty_cnt), 32'(e_empty));
        check({name, ".hold_solved"}, 32'(bus.solved), 32'(e_solved));
    endtask

    // ---------------- directed sequence ----------------
    logic [6:0] box_exp [9];

    initial begin
        bus.start = 1'b0;
        clear_board();
        box_exp = '{7'd0, 7'd1, 7'd2, 7'd9, 7'd10, 7'd11, 7'd18, 7'd19, 7'd20};

        #1 restart = 1'b1;
        repeat (2) @(posedge clka);
        @(negedge clka);
        check("reset.rd_en", 32'(bus.rd_en), 32'd0);
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.solved", 32'(bus.solved), 32'd0);
        check("reset.conflict", 32'(bus.conflict), 32'd0);
        check("reset.err_group", 32'(bus.err_group), 32'd0);
        check("reset.empty_cnt", 32'(bus.empty_cnt), 32'd0);
        check("reset.state", 32'(fsm_state), 32'd0);
        restart = 1'b0;

        // Valid solution, plus explicit address spot checks.
        valid_board();
        run_scan("valid", 1'b0);
        check("valid.solved_const", 32'(bus.solved), 32'd1);
        if (trace.size() == 243) begin
            for (int i = 0; i < 9; i++) begin
                check("addr.row0", 32'(trace[i]), 32'(i));
                check("addr.col0", 32'(trace[81 + i]), 32'(9 * i));
                check("addr.box0", 32'(trace[162 + i]), 32'(box_exp[i]));
            end
            check("addr.last", 32'(trace[242]), 32'd80);
        end else begin
            check("addr.trace_len", 32'(trace.size()), 32'd243);
        end

        clear_board();
        run_scan("all_zero", 1'b0);
        check("all_zero.empty_const", 32'(bus.empty_cnt), 32'd81);

        clear_board();
        board[3 * 9 + 0] = 4'd5;
        board[3 * 9 + 4] = 4'd5;
        run_scan("row_dup", 1'b0);
        check("row_dup.err_const", 32'(bus.err_group), 32'd3);
        check("row_dup.empty_const", 32'(bus.empty_cnt), 32'd79);

        clear_board();
        board[0]  = 4'd7;
        board[10] = 4'd7;
        run_scan("box_dup", 1'b0);
        check("box_dup.err_const", 32'(bus.err_group), 32'd18);

        clear_board();
        board[0] = 4'd12;
        run_scan("illegal", 1'b0);
        check("illegal.err_const", 32'(bus.err_group), 32'd0);
        check("illegal.conflict_const", 32'(bus.conflict), 32'd1);

        // Randomized boards with start glitches during the scan.
        for (int t = 0; t < 6; t++) begin
            valid_board();
            for (int e = 0; e < int'($urandom_range(0, 3)); e++)
                board[$urandom_range(0, 80)] = 4'($urandom_range(0, 15));
            run_scan("random", 1'b1);
        end

        // Restart in the middle of the column pass.
        valid_board();
        board[1] = board[0];
        @(negedge clka);
        bus.start = 1'b1;
        @(posedge clka);
        #1 bus.start = 1'b0;
        repeat (101) @(negedge clka);
        check("mid.busy", 32'(bus.busy), 32'd1);
        check("mid.conflict", 32'(bus.conflict), 32'd1);
        #1 restart = 1'b1;
        #1;
        check("restart.rd_en", 32'(bus.rd_en), 32'd0);
        check("restart.busy", 32'(bus.busy), 32'd0);
        check("restart.conflict", 32'(bus.conflict), 32'd0);
        check("restart.empty_cnt", 32'(bus.empty_cnt), 32'd0);
        check("restart.state", 32'(fsm_state), 32'd0);
        @(negedge clka);
        restart = 1'b0;
        run_scan("after_restart", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global time guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
